// File: rtl/posit_pkg.sv
// Shared definitions for the posit multiplier sequencer: state codes, stage ids
// and the special posit words.
package posit_pkg;

    localparam int POSIT_N = 32;

    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEC  = 3'd1;
    localparam logic [2:0] ST_MUL  = 3'd2;
    localparam logic [2:0] ST_ADJ  = 3'd3;
    localparam logic [2:0] ST_ENC  = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_DEC  = ST_DEC,
        S_MUL  = ST_MUL,
        S_ADJ  = ST_ADJ,
        S_ENC  = ST_ENC,
        S_OUT  = ST_OUT
    } seq_state_e;

    localparam logic [1:0] STAGE_DEC = 2'd0;
    localparam logic [1:0] STAGE_MUL = 2'd1;
    localparam logic [1:0] STAGE_ADJ = 2'd2;
    localparam logic [1:0] STAGE_ENC = 2'd3;

endpackage

// File: rtl/posit_mul_seq_watchdog.sv
// Per-stage watchdog: counts cycles since the current stage's start pulse and
// flags expiry when the stage has had TIMEOUT cycles to answer.
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // cnt_q equals the number of cycles elapsed since the start cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd1;
        end else if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/posit_mul_seq.sv
// Sequencer for the multi-cycle posit multiplier: steps decode, multiply,
// adjust and encode via start/done handshakes and holds the product for the consumer.
module posit_mul_seq
    import posit_pkg::*;
#(
    parameter int N       = POSIT_N,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic         dec_start,
    input  logic         dec_done,
    input  logic         dec_zero,
    input  logic         dec_nar,
    output logic         mul_start,
    input  logic         mul_done,
    output logic         adj_start,
    input  logic         adj_done,
    output logic         enc_start,
    input  logic         enc_done,
    input  logic [N-1:0] enc_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_err,
    output logic [1:0]   err_stage,
    output logic         busy
);

    localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ZERO = '0;

    seq_state_e   state_q, state_d;
    logic         first_q, first_d;
    logic [N-1:0] opA_q, opA_d;
    logic [N-1:0] opB_q, opB_d;
    logic [N-1:0] result_q, result_d;
    logic         err_q, err_d;
    logic [1:0]   errStage_q, errStage_d;

    logic         inStage;
    logic         doneSel;
    logic [1:0]   curStage;
    logic         doneAccept;
    logic         expire;

    always_comb begin
        inStage  = 1'b0;
        doneSel  = 1'b0;
        curStage = STAGE_DEC;
        case (state_q)
            S_DEC: begin
                inStage  = 1'b1;
                doneSel  = dec_done;
                curStage = STAGE_DEC;
            end
            S_MUL: begin
                inStage  = 1'b1;
                doneSel  = mul_done;
                curStage = STAGE_MUL;
            end
            S_ADJ: begin
                inStage  = 1'b1;
                doneSel  = adj_done;
                curStage = STAGE_ADJ;
            end
            S_ENC: begin
                inStage  = 1'b1;
                doneSel  = enc_done;
                curStage = STAGE_ENC;
            end
            default: begin
                inStage  = 1'b0;
                doneSel  = 1'b0;
                curStage = STAGE_DEC;
            end
        endcase
    end

    // A done seen in the start cycle belongs to an earlier request and is dropped
    assign doneAccept = inStage && !first_q && doneSel;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (inStage && first_q),
        .en_i     (inStage),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        opA_d      = opA_q;
        opB_d      = opB_q;
        result_d   = result_q;
        err_d      = err_q;
        errStage_d = errStage_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opA_d   = in_a;
                    opB_d   = in_b;
                    state_d = S_DEC;
                    first_d = 1'b1;
                end
            end
            S_DEC, S_MUL, S_ADJ, S_ENC: begin
                if (doneAccept) begin
                    case (state_q)
                        S_DEC: begin
                            if (dec_nar) begin
                                result_d = NAR;
                                state_d  = S_OUT;
                            end else if (dec_zero) begin
                                result_d = ZERO;
                                state_d  = S_OUT;
                            end else begin
                                state_d = S_MUL;
                                first_d = 1'b1;
                            end
                        end
                        S_MUL: begin
                            state_d = S_ADJ;
                            first_d = 1'b1;
                        end
                        S_ADJ: begin
                            state_d = S_ENC;
                            first_d = 1'b1;
                        end
                        default: begin
                            result_d = enc_result;
                            state_d  = S_OUT;
                        end
                    endcase
                end else if (expire) begin
                    state_d    = S_OUT;
                    err_d      = 1'b1;
                    errStage_d = curStage;
                    result_d   = NAR;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b0;
                    errStage_d = STAGE_DEC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            errStage_q <= STAGE_DEC;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            result_q   <= result_d;
            err_q      <= err_d;
            errStage_q <= errStage_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_OUT);
    assign op_a       = opA_q;
    assign op_b       = opB_q;
    assign out_result = result_q;
    assign out_err    = err_q;
    assign err_stage  = errStage_q;
    assign dec_start  = (state_q == S_DEC) && first_q;
    assign mul_start  = (state_q == S_MUL) && first_q;
    assign adj_start  = (state_q == S_ADJ) && first_q;
    assign enc_start  = (state_q == S_ENC) && first_q;

endmodule

// File: tb/tb_posit_mul_seq.sv
// Directed bench for posit_mul_seq with stub stages whose done latency can be
// set, suppressed or injected per stage.
module tb_posit_mul_seq;
    import posit_pkg::*;

    localparam int N       = 32;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready;
    logic [N-1:0] in_a, in_b, op_a, op_b;
    logic         dec_start, dec_done, dec_zero, dec_nar;
    logic         mul_start, mul_done, adj_start, adj_done;
    logic         enc_start, enc_done;
    logic [N-1:0] enc_result;
    logic         out_valid, out_ready;
    logic [N-1:0] out_result;
    logic         out_err;
    logic [1:0]   err_stage;
    logic         busy;

    int total = 0;
    int bad   = 0;

    int lat[4]       = '{2, 2, 2, 2};
    bit hang[4]      = '{0, 0, 0, 0};
    bit forceDone[4] = '{0, 0, 0, 0};
    int stCnt[4]     = '{0, 0, 0, 0};

    logic         decNar, decZero;
    logic [N-1:0] encVal;

    int firstStart[4];
    int startCount[4];
    int outCycle;
    int staleStage = -1;
    int staleCycle = 0;

    logic [3:0] startVec;
    assign startVec = {enc_start, adj_start, mul_start, dec_start};

    posit_mul_seq #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .op_a       (op_a),
        .op_b       (op_b),
        .dec_start  (dec_start),
        .dec_done   (dec_done),
        .dec_zero   (dec_zero),
        .dec_nar    (dec_nar),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .adj_start  (adj_start),
        .adj_done   (adj_done),
        .enc_start  (enc_start),
        .enc_done   (enc_done),
        .enc_result (enc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .err_stage  (err_stage),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stub stages: stCnt[i] is k in cycle start+k, so done rises lat[i] cycles after start
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (startVec[i]) begin
                stCnt[i] <= 1;
            end else if (stCnt[i] != 0) begin
                stCnt[i] <= stCnt[i] + 1;
            end
        end
    end

    assign dec_done   = ((stCnt[0] == lat[0]) && !hang[0]) || forceDone[0];
    assign mul_done   = ((stCnt[1] == lat[1]) && !hang[1]) || forceDone[1];
    assign adj_done   = ((stCnt[2] == lat[2]) && !hang[2]) || forceDone[2];
    assign enc_done   = ((stCnt[3] == lat[3]) && !hang[3]) || forceDone[3];
    assign dec_nar    = decNar;
    assign dec_zero   = decZero;
    assign enc_result = encVal;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called in cycle 1 of an accepted operation; returns in the first out_valid cycle
    task automatic waitOut(input int limit, input int stopStage);
        for (int i = 0; i < 4; i++) begin
            firstStart[i] = -1;
            startCount[i] = 0;
        end
        outCycle = -1;
        for (int k = 1; k <= limit; k++) begin
            for (int i = 0; i < 4; i++) begin
                forceDone[i] = (i == staleStage) && (k == staleCycle);
            end
            for (int i = 0; i < 4; i++) begin
                if (startVec[i]) begin
                    startCount[i]++;
                    if (firstStart[i] < 0) firstStart[i] = k;
                end
            end
            if (out_valid) begin
                outCycle = k;
                break;
            end
            if (stopStage >= 0 && startVec[stopStage]) break;
            tick();
        end
        for (int i = 0; i < 4; i++) forceDone[i] = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input int limit, input int stopStage);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitOut(limit, stopStage);
    endtask

    task automatic drainOutput();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        decNar    = 1'b0;
        decZero   = 1'b0;
        encVal    = 32'h4000_0000;

        #3;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dec_start", dec_start, 0);
        checkOutput("reset_out_result", out_result, 0);
        checkOutput("reset_op_a", op_a, 0);
        #4 rst_n = 1'b1;
        tick();

        // Normal operation, L=2 for every stage
        applyStimulus(32'h4000_0000, 32'h4000_0000, 40, -1);
        checkOutput("norm_dec_start", firstStart[0], 1);
        checkOutput("norm_mul_start", firstStart[1], 4);
        checkOutput("norm_adj_start", firstStart[2], 7);
        checkOutput("norm_enc_start", firstStart[3], 10);
        checkOutput("norm_out_cycle", outCycle, 13);
        checkOutput("norm_result", out_result, 32'h4000_0000);
        checkOutput("norm_err", out_err, 0);
        checkOutput("norm_in_ready", in_ready, 0);
        checkOutput("norm_op_b", op_b, 32'h4000_0000);
        drainOutput();
        checkOutput("norm_drain_valid", out_valid, 0);
        checkOutput("norm_drain_ready", in_ready, 1);

        // adj_done injected in the adj_start cycle must be ignored
        staleStage = 2;
        staleCycle = 7;
        encVal = 32'h3800_0000;
        applyStimulus(32'h4800_0000, 32'h3000_0000, 40, -1);
        staleStage = -1;
        checkOutput("stale_enc_start", firstStart[3], 10);
        checkOutput("stale_enc_count", startCount[3], 1);
        checkOutput("stale_out_cycle", outCycle, 13);
        checkOutput("stale_result", out_result, 32'h3800_0000);
        drainOutput();

        // NaR beats zero
        decNar  = 1'b1;
        decZero = 1'b1;
        applyStimulus(32'h8000_0000, 32'h0000_0000, 40, -1);
        checkOutput("nar_out_cycle", outCycle, 4);
        checkOutput("nar_no_mul", startCount[1], 0);
        checkOutput("nar_result", out_result, POSIT_NAR);
        checkOutput("nar_err", out_err, 0);
        drainOutput();

        decNar = 1'b0;
        applyStimulus(32'h0000_0000, 32'h4000_0000, 40, -1);
        checkOutput("zero_out_cycle", outCycle, 4);
        checkOutput("zero_no_mul", startCount[1], 0);
        checkOutput("zero_result", out_result, POSIT_ZERO);
        drainOutput();
        decZero = 1'b0;

        // Multiply stage never answers
        hang[1] = 1'b1;
        applyStimulus(32'h4000_0000, 32'h5000_0000, 60, -1);
        checkOutput("tmo_out_cycle", outCycle, 21);
        checkOutput("tmo_err", out_err, 1);
        checkOutput("tmo_err_stage", err_stage, 1);
        checkOutput("tmo_result", out_result, 32'h8000_0000);
        checkOutput("tmo_no_adj", startCount[2], 0);
        drainOutput();
        checkOutput("tmo_drain_err", out_err, 0);
        checkOutput("tmo_drain_stage", err_stage, 0);
        hang[1] = 1'b0;

        // mul_done arrives exactly at start+TIMEOUT
        lat[1] = 16;
        encVal = 32'h3C00_0000;
        applyStimulus(32'h4000_0000, 32'h4400_0000, 60, -1);
        checkOutput("edge_adj_start", firstStart[2], 21);
        checkOutput("edge_out_cycle", outCycle, 27);
        checkOutput("edge_err", out_err, 0);
        checkOutput("edge_result", out_result, 32'h3C00_0000);
        drainOutput();
        lat[1] = 2;

        // Backpressure with a new pair waiting
        encVal = 32'h4800_0000;
        applyStimulus(32'h5000_0000, 32'h4000_0000, 40, -1);
        checkOutput("bp_out_cycle", outCycle, 13);
        in_valid = 1'b1;
        in_a     = 32'h1111_1111;
        in_b     = 32'h2222_2222;
        for (int j = 0; j < 5; j++) begin
            checkOutput("bp_hold_result", out_result, 32'h4800_0000);
            checkOutput("bp_hold_in_ready", in_ready, 0);
            checkOutput("bp_hold_op_a", op_a, 32'h5000_0000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", in_ready, 1);
        checkOutput("bp_release_busy", busy, 0);
        checkOutput("bp_release_op_a", op_a, 32'h5000_0000);
        tick();
        in_valid = 1'b0;
        encVal   = 32'h4000_0000;
        waitOut(40, -1);
        checkOutput("bp_next_op_a", op_a, 32'h1111_1111);
        checkOutput("bp_next_dec_start", firstStart[0], 1);
        checkOutput("bp_next_out_cycle", outCycle, 13);
        drainOutput();

        // Reset pulse during ADJ
        applyStimulus(32'h4000_0000, 32'h4000_0000, 40, 2);
        checkOutput("rst_adj_reached", firstStart[2], 7);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_adj_start", adj_start, 0);
        checkOutput("rst_op_a", op_a, 0);
        checkOutput("rst_out_err", out_err, 0);
        #2 rst_n = 1'b1;
        tick();
        applyStimulus(32'h4000_0000, 32'h4000_0000, 40, -1);
        checkOutput("rst_fresh_out_cycle", outCycle, 13);
        checkOutput("rst_fresh_result", out_result, 32'h4000_0000);
        drainOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
